// File: rtl/sram_ctrl.sv
// Host-side controller for a single-port synchronous SRAM: single-word read/write
// requests over valid/ready, fixed-latency read capture and a zero-fill clear engine.
module sram_ctrl #(
    parameter int AW     = 4,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            CW   = $clog2(RD_LAT + 2);
    localparam logic [CW-1:0] LAT  = CW'(RD_LAT);
    localparam logic [AW-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, WR, RD, CLR} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] wdata_nxt, rdata_nxt;
    logic          wren_nxt, rsp_valid_nxt, busy_nxt, done_nxt;

    // Clear takes priority over a pending request, so readiness also depends on clr_start.
    assign req_ready = (state == IDLE) && !clr_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            mem_wren  <= wren_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rdata_nxt;
            clr_busy  <= busy_nxt;
            clr_done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        addr_nxt      = mem_addr;
        wdata_nxt     = mem_wdata;
        wren_nxt      = 1'b0;
        rsp_valid_nxt = 1'b0;
        rdata_nxt     = rsp_rdata;
        busy_nxt      = clr_busy;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt = CLR;
                    addr_nxt  = '0;
                    wdata_nxt = '0;
                    wren_nxt  = 1'b1;
                    busy_nxt  = 1'b1;
                end else if (req_valid) begin
                    addr_nxt = req_addr;
                    if (req_wr) begin
                        state_nxt = WR;
                        wdata_nxt = req_wdata;
                        wren_nxt  = 1'b1;
                    end else begin
                        state_nxt = RD;
                        cnt_nxt   = '0;
                    end
                end
            end
            WR: state_nxt = IDLE;
            RD: begin
                // The counter reaches RD_LAT on the edge where the SRAM output is valid.
                if (cnt == LAT) begin
                    rdata_nxt     = mem_rdata;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            CLR: begin
                if (mem_addr == LAST) begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    addr_nxt = mem_addr + 1'b1;
                    wren_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: SRAM models for RD_LAT 0/1/2 and an
// array-based reference of the memory contents driven by random traffic.
module tb_sram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_wr, clr_start;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_ready, rsp_valid, clr_busy, clr_done, mem_wren;
    logic [7:0] rsp_rdata, mem_wdata, mem_rdata;
    logic [3:0] mem_addr;

    logic       vValid, vWr, vClr;
    logic [3:0] vAddr;
    logic [7:0] vWdata;
    logic       l0Ready, l0RspValid, l0Busy, l0Done, l0Wren;
    logic [7:0] l0Rdata, l0Mwdata, l0Mrdata;
    logic [3:0] l0Maddr;
    logic       l2Ready, l2RspValid, l2Busy, l2Done, l2Wren;
    logic [7:0] l2Rdata, l2Mwdata, l2Mrdata;
    logic [3:0] l2Maddr;

    int total = 0;
    int bad = 0;
    int cycle = 0;

    logic [7:0] model [16];

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    sram_ctrl #(.AW(4), .DW(8), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .clr_start(clr_start),
        .clr_busy(clr_busy), .clr_done(clr_done), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
    );

    sram_ctrl #(.AW(4), .DW(8), .RD_LAT(0)) dutLat0 (
        .clk(clk), .rst_n(rst_n), .req_valid(vValid), .req_ready(l0Ready),
        .req_wr(vWr), .req_addr(vAddr), .req_wdata(vWdata),
        .rsp_valid(l0RspValid), .rsp_rdata(l0Rdata), .clr_start(vClr),
        .clr_busy(l0Busy), .clr_done(l0Done), .mem_addr(l0Maddr),
        .mem_wdata(l0Mwdata), .mem_wren(l0Wren), .mem_rdata(l0Mrdata)
    );

    sram_ctrl #(.AW(4), .DW(8), .RD_LAT(2)) dutLat2 (
        .clk(clk), .rst_n(rst_n), .req_valid(vValid), .req_ready(l2Ready),
        .req_wr(vWr), .req_addr(vAddr), .req_wdata(vWdata),
        .rsp_valid(l2RspValid), .rsp_rdata(l2Rdata), .clr_start(vClr),
        .clr_busy(l2Busy), .clr_done(l2Done), .mem_addr(l2Maddr),
        .mem_wdata(l2Mwdata), .mem_wren(l2Wren), .mem_rdata(l2Mrdata)
    );

    // SRAM macros: RD_LAT=1 registered, RD_LAT=0 combinational, RD_LAT=2 two-stage.
    logic [7:0] sram1 [16];
    logic [7:0] sram1Q;
    always @(posedge clk) begin
        if (mem_wren) sram1[mem_addr] <= mem_wdata;
        sram1Q <= sram1[mem_addr];
    end
    assign mem_rdata = sram1Q;

    logic [7:0] sram0 [16];
    always @(posedge clk) if (l0Wren) sram0[l0Maddr] <= l0Mwdata;
    assign l0Mrdata = sram0[l0Maddr];

    logic [7:0] sram2 [16];
    logic [7:0] sram2Q1, sram2Q2;
    always @(posedge clk) begin
        if (l2Wren) sram2[l2Maddr] <= l2Mwdata;
        sram2Q1 <= sram2[l2Maddr];
        sram2Q2 <= sram2Q1;
    end
    assign l2Mrdata = sram2Q2;

    task automatic send(input logic wr, input logic [3:0] a, input logic [7:0] d, output int hs);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        #1;
        while (!req_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL handshake_timeout: ready=%b required 1", req_ready);
        end
        @(posedge clk); #1 hs = cycle;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [7:0] d);
        int hs;
        send(1'b1, a, d, hs);
        total++;
        if ({mem_wren, mem_addr, mem_wdata} !== {1'b1, a, d}) begin
            bad++; $display("[TB] FAIL write_pins: got wren=%b addr=%h data=%h required 1 %h %h",
                            mem_wren, mem_addr, mem_wdata, a, d);
        end
        @(negedge clk);
        total++;
        if ({mem_wren, req_ready} !== 2'b01) begin
            bad++; $display("[TB] FAIL write_end: got wren=%b ready=%b required 0 1", mem_wren, req_ready);
        end
        model[a] = d;
    endtask

    // Entered on the first negedge after the read handshake; response due RD_LAT+1 edges later.
    task automatic wait_rsp(input logic [3:0] a);
        int k = 1;
        logic [7:0] exp = model[a];
        total++;
        if (mem_addr !== a || mem_wren !== 1'b0) begin
            bad++; $display("[TB] FAIL read_addr: got addr=%h wren=%b required %h 0", mem_addr, mem_wren, a);
        end
        while (rsp_valid !== 1'b1 && k < 10) begin
            @(negedge clk); k++;
        end
        total++;
        if (k !== 3) begin
            bad++; $display("[TB] FAIL read_latency: got %0d required 3", k);
        end
        total++;
        if (rsp_rdata !== exp) begin
            bad++; $display("[TB] FAIL read_data@%h: got %h required %h", a, rsp_rdata, exp);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== exp) begin
            bad++; $display("[TB] FAIL read_strobe_len: got valid=%b data=%h required 0 %h", rsp_valid, rsp_rdata, exp);
        end
    endtask

    task automatic read_word(input logic [3:0] a);
        int hs;
        send(1'b0, a, 8'h00, hs);
        wait_rsp(a);
    endtask

    task automatic check_reset_values(input string name);
        total++;
        if ({mem_wren, mem_addr, mem_wdata, rsp_valid, rsp_rdata, clr_busy, clr_done, req_ready}
            !== {1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            bad++; $display("[TB] FAIL %s: got wren=%b addr=%h wd=%h rv=%b rd=%h busy=%b done=%b ready=%b required all 0, ready 1",
                            name, mem_wren, mem_addr, mem_wdata, rsp_valid, rsp_rdata, clr_busy, clr_done, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset_state");
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        write_word(4'h1, 8'hAA);
        read_word(4'h1);
    endtask

    task automatic test_back_to_back();
        int h1, h2, n;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'h2; req_wdata = 8'h11;
        @(posedge clk); #1 h1 = cycle;
        @(negedge clk);
        req_addr = 4'h3; req_wdata = 8'h22;
        total++;
        if ({mem_wren, mem_addr, mem_wdata, req_ready} !== {1'b1, 4'h2, 8'h11, 1'b0}) begin
            bad++; $display("[TB] FAIL b2b_first: got wren=%b addr=%h data=%h ready=%b", mem_wren, mem_addr, mem_wdata, req_ready);
        end
        n = 0;
        #1;
        while (!req_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk); #1 h2 = cycle;
        total++;
        if (h2 - h1 !== 2) begin
            bad++; $display("[TB] FAIL b2b_spacing: got %0d cycles required 2", h2 - h1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if ({mem_wren, mem_addr, mem_wdata} !== {1'b1, 4'h3, 8'h22}) begin
            bad++; $display("[TB] FAIL b2b_second: got wren=%b addr=%h data=%h", mem_wren, mem_addr, mem_wdata);
        end
        model[2] = 8'h11;
        model[3] = 8'h22;
        @(negedge clk);
        read_word(4'h2);
        read_word(4'h3);
    endtask

    task automatic test_clear();
        int wrens = 0, dones = 0, firstJ = -1, lastJ = -1, doneJ = -1, seqBad = 0;
        write_word(4'hF, 8'h55);
        @(negedge clk); clr_start = 1'b1;
        @(negedge clk); clr_start = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            if (mem_wren) begin
                if (mem_addr !== 4'(wrens) || mem_wdata !== 8'h00 || clr_busy !== 1'b1) seqBad++;
                if (firstJ < 0) firstJ = j;
                lastJ = j;
                wrens++;
            end
            if (clr_done) begin
                dones++; doneJ = j;
            end
            @(negedge clk);
        end
        total++;
        if (wrens !== 16 || firstJ !== 1 || lastJ !== 16) begin
            bad++; $display("[TB] FAIL clear_wren: got %0d cycles %0d..%0d required 16 cycles 1..16", wrens, firstJ, lastJ);
        end
        total++;
        if (seqBad !== 0) begin
            bad++; $display("[TB] FAIL clear_sequence: got %0d bad cycles required 0", seqBad);
        end
        total++;
        if (dones !== 1 || doneJ !== 17) begin
            bad++; $display("[TB] FAIL clear_done: got %0d pulses at %0d required 1 at 17", dones, doneJ);
        end
        total++;
        if (mem_addr !== 4'hF || clr_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL clear_end: got addr=%h busy=%b required f 0", mem_addr, clr_busy);
        end
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        read_word(4'hF);
    endtask

    task automatic test_clear_priority();
        int n = 1;
        write_word(4'h5, 8'h77);
        @(negedge clk);
        clr_start = 1'b1; req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'h5;
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL prio_ready: got %b required 0", req_ready);
        end
        @(negedge clk); clr_start = 1'b0;
        #1;
        while (!req_ready && n < 40) begin
            @(negedge clk); #1; n++;
        end
        total++;
        if (n !== 17 || clr_done !== 1'b1) begin
            bad++; $display("[TB] FAIL prio_accept: got cycle %0d done=%b required 17 1", n, clr_done);
        end
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        wait_rsp(4'h5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [3:0] a = 4'($urandom_range(0, 15));
            logic [7:0] d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) write_word(a, d);
            else read_word(a);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int hs, pulses;
        send(1'b0, 4'h4, 8'h00, hs);
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset_mid_read");
        pulses = 0;
        @(negedge clk); rst_n = 1'b1;
        repeat (4) begin
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        total++;
        if (pulses !== 0) begin
            bad++; $display("[TB] FAIL reset_read_rsp: got %0d pulses required 0", pulses);
        end
        clr_start = 1'b1;
        @(negedge clk); clr_start = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (mem_wren !== 1'b1 || clr_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_clear_pre: got wren=%b busy=%b required 1 1", mem_wren, clr_busy);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset_mid_clear");
        pulses = 0;
        @(negedge clk); rst_n = 1'b1;
        repeat (20) begin
            if (clr_done || mem_wren) pulses++;
            @(negedge clk);
        end
        total++;
        if (pulses !== 0) begin
            bad++; $display("[TB] FAIL reset_clear_done: got %0d active cycles required 0", pulses);
        end
        write_word(4'h9, 8'hC3);
        read_word(4'h9);
    endtask

    task automatic test_latency_variants();
        int k0 = -1, k2 = -1;
        logic [7:0] d0 = 8'h00, d2 = 8'h00;
        @(negedge clk);
        vValid = 1'b1; vWr = 1'b1; vAddr = 4'h6; vWdata = 8'h3C;
        @(negedge clk); vValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vValid = 1'b1; vWr = 1'b0;
        #1;
        total++;
        if ({l0Ready, l2Ready} !== 2'b11) begin
            bad++; $display("[TB] FAIL lat_ready: got %b%b required 11", l0Ready, l2Ready);
        end
        @(negedge clk); vValid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (l0RspValid === 1'b1 && k0 < 0) begin k0 = k; d0 = l0Rdata; end
            if (l2RspValid === 1'b1 && k2 < 0) begin k2 = k; d2 = l2Rdata; end
            @(negedge clk);
        end
        total++;
        if (k0 !== 2 || d0 !== 8'h3C) begin
            bad++; $display("[TB] FAIL lat0_read: got k=%0d data=%h required 2 3c", k0, d0);
        end
        total++;
        if (k2 !== 4 || d2 !== 8'h3C) begin
            bad++; $display("[TB] FAIL lat2_read: got k=%0d data=%h required 4 3c", k2, d2);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; clr_start = 1'b0;
        vValid = 1'b0; vWr = 1'b0; vAddr = '0; vWdata = '0; vClr = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_clear();
        test_clear_priority();
        test_random();
        test_reset_mid();
        test_latency_variants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
